// File: rtl/isqrt_stage_pipe.sv
// isqrt_stage_pipe: pipelined unsigned integer square root, y = floor(sqrt(x)).
// Each stage resolves BPS root bits MSB first using the restoring
// digit-by-digit method. A new operand may enter every cycle, and each
// result leaves STAGES cycles after its operand.
module isqrt_stage_pipe #(
    parameter int STAGES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        x_vld,
    input  logic [31:0] x,
    output logic        y_vld,
    output logic [15:0] y
);

    localparam int BPS = 16 / STAGES;

    generate
        if (!(STAGES == 1 || STAGES == 2 || STAGES == 4 || STAGES == 8 || STAGES == 16)) begin : g_bad_stages
            $error("isqrt_stage_pipe: STAGES must be one of 1, 2, 4, 8, 16");
        end
    endgenerate

    // One restoring step. The partial root is kept right-justified, so the
    // trial value is {root, 01}. rem never exceeds 2*root before the shift,
    // and the partial root has at most 15 bits before the final step. This
    // means the top two bits of rem are always zero and can be dropped.
    function automatic logic [33:0] root_digit(
        input logic [31:0] rad,
        input logic [15:0] root,
        input logic [17:0] rem,
        input int          bit_idx
    );
        logic [17:0] rem_sh;
        logic [17:0] trial;
        logic [33:0] res;
        rem_sh = {rem[15:0], rad[2*bit_idx +: 2]};
        trial  = {root, 2'b01};
        if (rem_sh >= trial) begin
            res = {root[14:0], 1'b1, rem_sh - trial};
        end else begin
            res = {root[14:0], 1'b0, rem_sh};
        end
        return res;
    endfunction

    // Per-stage registered tuple {vld, x, root, rem}
    logic [STAGES-1:0] vld_r;
    logic [31:0]       x_r    [STAGES];
    logic [15:0]       root_r [STAGES];
    logic [17:0]       rem_r  [STAGES];

    // Stage inputs and the results computed for each stage
    logic [STAGES-1:0] in_vld_s;
    logic [31:0]       in_x_s      [STAGES];
    logic [15:0]       in_root_s   [STAGES];
    logic [17:0]       in_rem_s    [STAGES];
    logic [15:0]       nxt_root_s  [STAGES];
    logic [17:0]       nxt_rem_s   [STAGES];
    logic [33:0]       step_s;

    // Route stage inputs: stage 0 takes the port, later stages take the previous register
    always_comb begin
        in_vld_s[0]  = x_vld;
        in_x_s[0]    = x;
        in_root_s[0] = 16'h0000;
        in_rem_s[0]  = 18'h00000;
        for (int k = 1; k < STAGES; k++) begin
            in_vld_s[k]  = vld_r[k-1];
            in_x_s[k]    = x_r[k-1];
            in_root_s[k] = root_r[k-1];
            in_rem_s[k]  = rem_r[k-1];
        end
    end

    // Resolve this stage's BPS root bits, MSB first
    always_comb begin
        step_s = 34'h0;
        for (int k = 0; k < STAGES; k++) begin
            step_s = {in_root_s[k], in_rem_s[k]};
            for (int j = 0; j < BPS; j++) begin
                step_s = root_digit(in_x_s[k], step_s[33:18], step_s[17:0], 15 - k*BPS - j);
            end
            nxt_root_s[k] = step_s[33:18];
            nxt_rem_s[k]  = step_s[17:0];
        end
    end

    // Stage registers: valids advance every cycle, data loads only for a valid operand
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r              <= '0;
            root_r[STAGES-1]   <= 16'h0000;
        end else begin
            vld_r <= in_vld_s;
            for (int k = 0; k < STAGES; k++) begin
                if (in_vld_s[k]) begin
                    x_r[k]    <= in_x_s[k];
                    root_r[k] <= nxt_root_s[k];
                    rem_r[k]  <= nxt_rem_s[k];
                end else begin
                    x_r[k]    <= x_r[k];
                    root_r[k] <= root_r[k];
                    rem_r[k]  <= rem_r[k];
                end
            end
        end
    end

    // The last stage's radicand and remainder are kept only for tuple uniformity
    logic unused_s;
    assign unused_s = ^{x_r[STAGES-1], rem_r[STAGES-1]};

    assign y_vld = vld_r[STAGES-1];
    assign y     = root_r[STAGES-1];

endmodule

// File: tb/tb_isqrt_stage_pipe.sv
// Bench for isqrt_stage_pipe. Five instances (STAGES=16,8,4,2,1) share the
// same stimulus. Each instance has its own expected-result queue and monitor.
module tb_isqrt_stage_pipe;

    localparam int NDUT = 5;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        x_vld = 1'b0;
    logic [31:0] x     = 32'h0;
    logic        y_vld_a [NDUT];
    logic [15:0] y_a     [NDUT];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          mon_en   = 1'b0;
    int          exp_q [NDUT][$];
    int          cyc_q [NDUT][$];
    logic [15:0] last_y [NDUT];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    genvar gi;
    generate
        for (gi = 0; gi < NDUT; gi++) begin : g_dut
            localparam int ST = 16 >> gi;
            int e;
            int c;

            isqrt_stage_pipe #(.STAGES(ST)) dut (
                .clk   (clk),
                .rst   (rst),
                .x_vld (x_vld),
                .x     (x),
                .y_vld (y_vld_a[gi]),
                .y     (y_a[gi])
            );

            always @(posedge clk) begin
                #1;
                if (mon_en) begin
                    if (rst) begin
                        n_checks++;
                        if (y_vld_a[gi] !== 1'b0 || y_a[gi] !== 16'h0000) begin
                            n_fail++;
                            $display("FAIL reset_out S=%0d: got y_vld=%b y=%h, want 0/0000", ST, y_vld_a[gi], y_a[gi]);
                        end
                        last_y[gi] = 16'h0000;
                    end else if (y_vld_a[gi] === 1'b1) begin
                        if (exp_q[gi].size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_y_vld S=%0d cyc=%0d: got y=%h, want no result", ST, cyc, y_a[gi]);
                        end else begin
                            e = exp_q[gi].pop_front();
                            c = cyc_q[gi].pop_front();
                            n_checks++;
                            if (y_a[gi] !== e[15:0]) begin
                                n_fail++;
                                $display("FAIL y_value S=%0d cyc=%0d: got %h, want %h", ST, cyc, y_a[gi], e[15:0]);
                            end
                            n_checks++;
                            if (cyc - c != ST) begin
                                n_fail++;
                                $display("FAIL latency S=%0d: got %0d, want %0d", ST, cyc - c, ST);
                            end
                            last_y[gi] = e[15:0];
                        end
                    end else begin
                        n_checks++;
                        if (y_vld_a[gi] !== 1'b0 || y_a[gi] !== last_y[gi]) begin
                            n_fail++;
                            $display("FAIL hold S=%0d cyc=%0d: got y_vld=%b y=%h, want 0/%h", ST, cyc, y_vld_a[gi], y_a[gi], last_y[gi]);
                        end
                    end
                end
            end
        end
    endgenerate

    // Reference model: bitwise binary search on r*r <= v
    function automatic logic [15:0] ref_isqrt(input logic [31:0] v);
        logic [15:0] r;
        logic [15:0] t;
        r = 16'h0000;
        for (int b = 15; b >= 0; b--) begin
            t = r | (16'h0001 << b);
            if ({48'h0, t} * {48'h0, t} <= {32'h0, v}) r = t;
        end
        return r;
    endfunction

    // One cycle of stimulus. An expected result is queued only for an
    // operand that is accepted. Asserting reset drops all pending expectations.
    task automatic drive(input bit r, input bit v, input logic [31:0] val, input int expv);
        @(negedge clk);
        if (r) begin
            for (int i = 0; i < NDUT; i++) begin
                exp_q[i].delete();
                cyc_q[i].delete();
            end
        end
        rst   = r;
        x_vld = v;
        x     = v ? val : $urandom;
        if (v && !r) begin
            for (int i = 0; i < NDUT; i++) begin
                exp_q[i].push_back(expv);
                cyc_q[i].push_back(cyc);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 0);
    endtask

    task automatic drain(input string name);
        int pending;
        for (int w = 0; w < 40; w++) begin
            pending = 0;
            for (int i = 0; i < NDUT; i++) pending += exp_q[i].size();
            if (pending == 0) break;
            idle(1);
        end
        idle(2);
        for (int i = 0; i < NDUT; i++) begin
            n_checks++;
            if (exp_q[i].size() != 0) begin
                n_fail++;
                $display("FAIL drain_%s dut%0d: got %0d pending results, want 0", name, i, exp_q[i].size());
            end
        end
    endtask

    task automatic test_reset();
        mon_en = 1'b1;
        drive(1'b1, 1'b1, 32'h0000_0010, 4);
        drive(1'b1, 1'b1, 32'h0000_0019, 5);
        drive(1'b1, 1'b0, 32'h0, 0);
        for (int i = 0; i < NDUT; i++) begin
            n_checks++;
            if (y_vld_a[i] !== 1'b0 || y_a[i] !== 16'h0000) begin
                n_fail++;
                $display("FAIL test_reset dut%0d: got y_vld=%b y=%h, want 0/0000", i, y_vld_a[i], y_a[i]);
            end
        end
        idle(2);
        drain("reset");
    endtask

    task automatic test_single();
        logic [31:0] xs [5];
        int          ys [5];
        xs = '{32'd0, 32'd1, 32'd15, 32'd16, 32'd17};
        ys = '{0, 1, 3, 4, 4};
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, xs[i], ys[i]);
            idle(3);
        end
        drain("single");
    endtask

    task automatic test_extremes();
        drive(1'b0, 1'b1, 32'hFFFF_FFFF, 16'hFFFF);
        drive(1'b0, 1'b1, 32'hFFFE_0001, 16'hFFFF);
        drive(1'b0, 1'b1, 32'hFFFE_0000, 16'hFFFE);
        drive(1'b0, 1'b1, 32'h0001_0000, 16'h0100);
        drive(1'b0, 1'b1, 32'h0000_FFFF, 16'h00FF);
        drain("extremes");
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        logic [31:0] r;
        drive(1'b0, 1'b1, 32'd36, 6);
        drive(1'b0, 1'b1, 32'd100, 10);
        drive(1'b0, 1'b1, 32'd49, 7);
        for (int i = 0; i < 1000; i++) begin
            v = $urandom;
            if (i % 4 == 0) begin
                r = 32'($urandom_range(0, 65535));
                v = r * r - ((i % 8 == 0) ? 32'd1 : 32'd0);
            end
            drive(1'b0, 1'b1, v, int'(ref_isqrt(v)));
        end
        drain("back_to_back");
    endtask

    task automatic test_bubbles();
        drive(1'b0, 1'b1, 32'd4, 2);
        drive(1'b0, 1'b0, 32'h0, 0);
        drive(1'b0, 1'b0, 32'h0, 0);
        drive(1'b0, 1'b1, 32'd9, 3);
        drive(1'b0, 1'b0, 32'h0, 0);
        drive(1'b0, 1'b1, 32'd25, 5);
        drain("bubbles");
    endtask

    task automatic test_reset_midflight();
        drive(1'b0, 1'b1, 32'd144, 12);
        drive(1'b0, 1'b1, 32'd169, 13);
        drive(1'b0, 1'b1, 32'd196, 14);
        drive(1'b1, 1'b1, 32'd225, 15);
        drive(1'b0, 1'b1, 32'd81, 9);
        drain("reset_midflight");
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) last_y[i] = 16'h0000;
        test_reset();
        test_single();
        test_extremes();
        test_back_to_back();
        test_bubbles();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
